// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Shares one single-ported, variable-latency memory between the fetch stage
// (instruction reads) and the memory stage (word/byte loads and stores).
// One access is in flight at a time. The memory interface is registered and
// held stable until mem_ack_i. Read data returns with a one-cycle valid
// pulse. Data accesses win arbitration by default. A streak counter makes
// sure fetch is served after STARVE_LIMIT consecutive data grants made while
// fetch was waiting.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   if_req_i       fetch read request (held with if_addr_i until if_valid_o)
//   if_addr_i      fetch address
//   if_rdata_o     fetch read data, valid with if_valid_o
//   if_valid_o     one-cycle completion pulse for fetch
//   if_stall_o     fetch must hold (if_req_i & ~if_valid_o)
//   dm_req_i       data request (held with all dm_* fields until dm_valid_o)
//   dm_we_i        1 = store, 0 = load
//   dm_byte_i      byte access, passed through to memory
//   dm_addr_i      data address
//   dm_wdata_i     store data
//   dm_rdata_o     load data, valid with dm_valid_o
//   dm_valid_o     one-cycle completion pulse for loads and stores
//   dm_stall_o     memory stage must hold (dm_req_i & ~dm_valid_o)
//   mem_req_o      memory request (registered)
//   mem_we_o       memory write enable (registered)
//   mem_byte_o     byte access (registered)
//   mem_addr_o     memory address (registered)
//   mem_wdata_o    memory write data (registered)
//   mem_rdata_i    memory read data, sampled when mem_ack_i = 1
//   mem_ack_i      memory completion; may assert in the first mem_req_o cycle
// ---------------------------------------------------------------------------
module imem_dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4    // 1..15
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  // data side
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic              dm_byte_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              dm_stall_o,
  // memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              mem_byte_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e              state_q;
  logic [3:0]          streak_q, streak_d;
  logic                grant_dm, grant_if;

  logic                mem_req_q, mem_we_q, mem_byte_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
  logic                if_valid_q, dm_valid_q;

  // -------------------------------------------------------------------------
  // Grant decision, only meaningful in IDLE. Data wins unless fetch is
  // waiting and the streak has reached the limit. Because the streak never
  // exceeds LIMIT, exactly one grant fires whenever a request is present.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state_q == IDLE) begin
      if (dm_req_i && (!if_req_i || (streak_q < LIMIT))) begin
        grant_dm = 1'b1;
      end else if (if_req_i && (!dm_req_i || (streak_q == LIMIT))) begin
        grant_if = 1'b1;
      end
    end
  end

  // Streak counts data grants that bypassed a waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (grant_dm) begin
      if (if_req_i) begin
        streak_d = (streak_q == LIMIT) ? streak_q : streak_q + 4'd1;
      end else begin
        streak_d = 4'd0;
      end
    end else if (grant_if) begin
      streak_d = 4'd0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM with registered memory interface and registered valid pulses.
  // Valid is set on the ack edge, so it is high for exactly the RESP cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, regardless of statement order.
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      streak_q   <= streak_d;

      unique case (state_q)
        IDLE: begin
          // mem_ack_i is deliberately ignored here.
          if (grant_dm) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we_i;
            mem_byte_q  <= dm_byte_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
            state_q     <= BUSY_DM;
          end else if (grant_if) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= if_addr_i;
            state_q     <= BUSY_IF;
          end
        end

        // A requester dropping its req while busy does not abort the access.
        BUSY_IF: begin
          if (mem_ack_i) begin
            if_rdata_q <= mem_rdata_i;
            if_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= RESP;
          end
        end

        BUSY_DM: begin
          if (mem_ack_i) begin
            // Stores leave the last load data untouched.
            if (!mem_we_q) begin
              dm_rdata_q <= mem_rdata_i;
            end
            dm_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= RESP;
          end
        end

        // Turnaround cycle: the valid pulse is visible, no grant is made.
        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Stalls are the only combinational input-to-output paths.
  // -------------------------------------------------------------------------
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_byte_o  = mem_byte_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_valid_o  = dm_valid_q;

  assign if_stall_o  = if_req_i & ~if_valid_q;
  assign dm_stall_o  = dm_req_i & ~dm_valid_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_dmem_arbiter
//
// Directed bench for imem_dmem_arbiter. A small memory responder acks a
// configurable number of cycles after mem_req_o rises (0 = same cycle), or
// can be switched off so the stimulus drives mem_ack directly.
// ---------------------------------------------------------------------------
module tb_imem_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid, if_stall;
  logic              dm_req, dm_we, dm_byte;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid, dm_stall;
  logic              mem_req, mem_we, mem_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  // memory responder controls
  bit              auto_mem = 1'b0;
  int              lat      = 0;
  logic [31:0]     rdata_val = '0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_rdata_o (if_rdata),
    .if_valid_o (if_valid),
    .if_stall_o (if_stall),
    .dm_req_i   (dm_req),
    .dm_we_i    (dm_we),
    .dm_byte_i  (dm_byte),
    .dm_addr_i  (dm_addr),
    .dm_wdata_i (dm_wdata),
    .dm_rdata_o (dm_rdata),
    .dm_valid_o (dm_valid),
    .dm_stall_o (dm_stall),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_byte_o (mem_byte),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ack_i  (mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks `lat` cycles after mem_req rises.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_mem) begin
        if (mem_req) begin
          mem_ack   = (cnt == lat);
          mem_rdata = rdata_val;
          cnt       = (cnt == lat) ? 0 : cnt + 1;
        end else begin
          mem_ack = 1'b0;
          cnt     = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] exp_addr [6];
    logic [31:0] exp_strk [6];
    logic        prev_req;
    int          g;

    rst = 1'b1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_byte = 0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 0; mem_rdata = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_mem_req",  {31'd0, mem_req},  32'd0);
    check("rst_mem_addr", mem_addr,          32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_dm_rdata", dm_rdata,          32'd0);
    check("rst_streak",   {28'd0, dut.streak_q}, 32'd0);
    rst = 1'b0;
    auto_mem = 1'b1;

    // ---------------- fetch only, ack 2 cycles after mem_req rises ----------
    lat = 2; rdata_val = 32'h2402_0005;
    if_req = 1; if_addr = 32'h0000_0040;
    #1 check("f_stall_idle", {31'd0, if_stall}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("f_mem_req%0d", c),  {31'd0, mem_req},  32'd1);
      check($sformatf("f_mem_addr%0d", c), mem_addr,          32'h40);
      check($sformatf("f_mem_we%0d", c),   {31'd0, mem_we},   32'd0);
      check($sformatf("f_stall%0d", c),    {31'd0, if_stall}, 32'd1);
      check($sformatf("f_valid%0d", c),    {31'd0, if_valid}, 32'd0);
    end
    tick();
    check("f_valid",    {31'd0, if_valid}, 32'd1);
    check("f_rdata",    if_rdata,          32'h2402_0005);
    check("f_stall_lo", {31'd0, if_stall}, 32'd0);
    check("f_req_drop", {31'd0, mem_req},  32'd0);
    if_req = 0;
    tick();
    check("f_valid_1cyc", {31'd0, if_valid}, 32'd0);

    // ---------------- simultaneous requests: data first ----------------
    lat = 0; rdata_val = 32'h1111_1111;
    dm_req = 1; dm_we = 0; dm_byte = 0; dm_addr = 32'h100;
    if_req = 1; if_addr = 32'h44;
    tick();  // data ack cycle k
    check("s_dm_addr",  mem_addr,          32'h100);
    check("s_if_stall", {31'd0, if_stall}, 32'd1);
    check("s_dm_stall", {31'd0, dm_stall}, 32'd1);
    tick();  // k+1
    check("s_dm_valid", {31'd0, dm_valid}, 32'd1);
    check("s_dm_rdata", dm_rdata,          32'h1111_1111);
    check("s_if_stall2",{31'd0, if_stall}, 32'd1);
    check("s_no_grant", {31'd0, mem_req},  32'd0);
    dm_req = 0;
    rdata_val = 32'h2222_2222;
    tick();  // k+2: IDLE, fetch granted at end of this cycle
    check("s_idle_req", {31'd0, mem_req},  32'd0);
    check("s_if_stall3",{31'd0, if_stall}, 32'd1);
    tick();
    check("s_if_addr",  mem_addr,          32'h44);
    check("s_if_req",   {31'd0, mem_req},  32'd1);
    tick();
    check("s_if_valid", {31'd0, if_valid}, 32'd1);
    check("s_if_rdata", if_rdata,          32'h2222_2222);
    check("s_streak",   {28'd0, dut.streak_q}, 32'd0);
    if_req = 0;
    tick();

    // ---------------- byte store ----------------
    lat = 1; rdata_val = 32'hDEAD_BEEF;
    dm_req = 1; dm_we = 1; dm_byte = 1; dm_addr = 32'h203; dm_wdata = 32'hAB;
    tick();
    check("b_mem_we",    {31'd0, mem_we},   32'd1);
    check("b_mem_byte",  {31'd0, mem_byte}, 32'd1);
    check("b_mem_addr",  mem_addr,          32'h203);
    check("b_mem_wdata", mem_wdata,         32'hAB);
    tick();
    check("b_hold_wdata", mem_wdata,        32'hAB);
    tick();
    check("b_dm_valid",  {31'd0, dm_valid}, 32'd1);
    check("b_dm_rdata",  dm_rdata,          32'h1111_1111);
    dm_req = 0; dm_we = 0; dm_byte = 0;
    tick();
    check("b_valid_1cyc", {31'd0, dm_valid}, 32'd0);

    // ---------------- zero-wait ack, back-to-back data ----------------
    lat = 0; rdata_val = 32'h0000_5A5A;
    dm_req = 1; dm_addr = 32'h10;   // grant cycle t
    tick();                         // t+1
    check("z_mem_req",  {31'd0, mem_req},  32'd1);
    check("z_valid_t1", {31'd0, dm_valid}, 32'd0);
    tick();                         // t+2
    check("z_valid_t2", {31'd0, dm_valid}, 32'd1);
    check("z_rdata",    dm_rdata,          32'h0000_5A5A);
    dm_addr = 32'h14;               // new request seen in next IDLE
    tick();                         // t+3: IDLE, grant
    check("z_idle_t3",  {31'd0, mem_req},  32'd0);
    check("z_valid_t3", {31'd0, dm_valid}, 32'd0);
    tick();                         // t+4
    check("z_req_t4",   {31'd0, mem_req},  32'd1);
    check("z_addr_t4",  mem_addr,          32'h14);
    tick();
    dm_req = 0;
    tick();

    // ---------------- starvation: DM,DM,DM,DM,IF,DM ----------------
    exp_addr = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h80, 32'h300};
    exp_strk = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};
    lat = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    if_req = 1; if_addr = 32'h80;
    prev_req = mem_req;
    g = 0;
    for (int c = 0; c < 60 && g < 6; c++) begin
      tick();
      if (mem_req && !prev_req) begin
        check($sformatf("st_grant%0d", g),  mem_addr,               exp_addr[g]);
        check($sformatf("st_streak%0d", g), {28'd0, dut.streak_q},  exp_strk[g]);
        g++;
      end
      prev_req = mem_req;
    end
    check("st_grant_count", g, 32'd6);
    dm_req = 0; if_req = 0;
    repeat (4) tick();
    check("st_drained", {31'd0, mem_req}, 32'd0);

    // ---------------- reset in the middle of a data access ----------------
    auto_mem = 1'b0; mem_ack = 0;
    dm_req = 1; dm_addr = 32'h400;
    tick();
    check("r_busy_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1; dm_req = 0;
    #1;
    check("r_req_async",  {31'd0, mem_req},  32'd0);
    check("r_addr_async", mem_addr,          32'd0);
    check("r_rdata_rst",  dm_rdata,          32'd0);
    check("r_streak_rst", {28'd0, dut.streak_q}, 32'd0);
    mem_ack = 1;
    tick();
    rst = 1'b0;
    tick();
    check("r_no_valid",  {31'd0, dm_valid}, 32'd0);
    check("r_idle_ack",  {31'd0, mem_req},  32'd0);
    tick();
    check("r_no_valid2", {31'd0, dm_valid}, 32'd0);
    check("r_if_valid",  {31'd0, if_valid}, 32'd0);
    mem_ack = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
